// File: rtl/nn_pkg.sv
// Constants and FSM state type shared by the forward and transposed
// matrix-vector multipliers of the network.
package nn_pkg;

    localparam int NN_ROWS = 3;
    localparam int NN_COLS = 2;
    localparam int NN_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nn_state_e;

    // Index counter width; a single-entry dimension still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_transpose_mult_if.sv
// Operand/result bus of the transposed multiplier: matrix and error vector in,
// result vector out, each side with its own valid/ready handshake.
interface matrix_transpose_mult_if
    import nn_pkg::*;
#(
    parameter int ROWS = NN_ROWS,
    parameter int COLS = NN_COLS,
    parameter int W    = NN_W
) ();

    logic [ROWS*COLS*W-1:0] a;
    logic [ROWS*W-1:0]      e;
    logic                   in_valid;
    logic                   in_ready;
    logic [COLS*W-1:0]      z;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output a, e, in_valid, out_ready,
        input  in_ready, z, out_valid
    );

    modport slave (
        input  a, e, in_valid, out_ready,
        output in_ready, z, out_valid
    );

endinterface

// File: rtl/nn_mac.sv
// Combinational multiply-accumulate: the product is truncated to W bits
// before being added, and the sum wraps modulo 2^W.
module nn_mac
    import nn_pkg::*;
#(
    parameter int W = NN_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] acc_in_i,
    output logic [W-1:0] acc_out_o
);

    logic [W-1:0] prod_s;

    assign prod_s    = W'(a_i * b_i);
    assign acc_out_o = acc_in_i + prod_s;

endmodule

// File: rtl/matrix_transpose_mult.sv
// Sequential z = A^T * e using one shared MAC, column-outer / row-inner,
// one product per cycle between a capture and a held result.
module matrix_transpose_mult
    import nn_pkg::*;
#(
    parameter int ROWS = NN_ROWS,
    parameter int COLS = NN_COLS,
    parameter int W    = NN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_transpose_mult_if.slave  bus
);

    localparam int IW = idx_width(ROWS);
    localparam int JW = idx_width(COLS);

    nn_state_e     state_q;
    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [W-1:0]  a_q [ROWS][COLS];
    logic [W-1:0]  e_q [ROWS];
    logic [W-1:0]  z_q [COLS];
    logic          in_ready_q;
    logic          out_valid_q;

    logic [W-1:0]  mac_a_s;
    logic [W-1:0]  mac_b_s;
    logic [W-1:0]  mac_acc_s;
    logic [W-1:0]  mac_out_s;

    // Route the current (i, j) operands and accumulator slot to the MAC.
    always_comb begin
        mac_a_s   = a_q[i_q][j_q];
        mac_b_s   = e_q[i_q];
        mac_acc_s = z_q[j_q];
    end

    nn_mac #(.W(W)) u_mac (
        .a_i       (mac_a_s),
        .b_i       (mac_b_s),
        .acc_in_i  (mac_acc_s),
        .acc_out_o (mac_out_s)
    );

    // Controller: capture, MAC sequencing, result hold and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= {IW{1'b0}};
            j_q         <= {JW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                e_q[r] <= {W{1'b0}};
                for (int c = 0; c < COLS; c++) begin
                    a_q[r][c] <= {W{1'b0}};
                end
            end
            for (int c = 0; c < COLS; c++) begin
                z_q[c] <= {W{1'b0}};
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int r = 0; r < ROWS; r++) begin
                            e_q[r] <= bus.e[(ROWS-1-r)*W +: W];
                            for (int c = 0; c < COLS; c++) begin
                                a_q[r][c] <= bus.a[(ROWS*COLS-1-(r*COLS+c))*W +: W];
                            end
                        end
                        for (int c = 0; c < COLS; c++) begin
                            z_q[c] <= {W{1'b0}};
                        end
                        i_q        <= {IW{1'b0}};
                        j_q        <= {JW{1'b0}};
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    z_q[j_q] <= mac_out_s;
                    if (i_q == IW'(ROWS-1)) begin
                        // The last row of the last column ends the pass; counters hold there.
                        if (j_q == JW'(COLS-1)) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            i_q <= {IW{1'b0}};
                            j_q <= j_q + JW'(1);
                        end
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_z
        assign bus.z[(COLS-1-c)*W +: W] = z_q[c];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

endmodule
